// File: rtl/output_quantizer_slv_if.sv
// AXI-Stream beat bundle between the quantizer and the write-back DMA.
// Ports: tvalid/tdata/tlast from master, tready from slave.
interface output_quantizer_slv_if #(
    parameter int DW = 64
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/output_quantizer_slv.sv
// Deskews systolic column sums, requantizes each lane and streams vectors.
// Ports: clk_i/rst_n_i, en_i/valid_i/sum_i (array side), start_i/num_vec_i/
// shift_i (job), stall_o, m_axis (AXI-Stream master), done_o, drop_o.
module output_quantizer_slv #(
    parameter int  W_g          = 8,
    parameter int  R_g          = 8,
    parameter int  FIFO_DEPTH_g = 4,
    localparam int ACC_W        = 2 * W_g + $clog2(R_g)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic                   valid_i,
    input  logic [R_g*ACC_W-1:0]   sum_i,
    input  logic                   start_i,
    input  logic [15:0]            num_vec_i,
    input  logic [4:0]             shift_i,
    output logic                   stall_o,
    output_quantizer_slv_if.master m_axis,
    output logic                   done_o,
    output logic                   drop_o
);

    localparam int AW = $clog2(FIFO_DEPTH_g);
    localparam int CW = AW + 1;
    localparam int DW = R_g * W_g;

    localparam logic [4:0] SH_MAX = 5'(ACC_W - 1);
    localparam logic signed [ACC_W:0] Q_MAX =
        (ACC_W + 1)'((1 <<< (W_g - 1)) - 1);
    localparam logic signed [ACC_W:0] Q_MIN = ~Q_MAX;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t r_state;

    logic [15:0]        r_num_vec;
    logic [4:0]         r_shift;
    logic [15:0]        r_out_cnt;
    logic               r_done;
    logic               r_drop;

    logic [R_g-2:0]     r_vld;
    logic [ACC_W-1:0]   w_col [R_g];

    logic               r_q_valid;
    logic [DW-1:0]      r_q_data;
    logic [DW-1:0]      w_quant;

    logic [DW-1:0]      r_mem [FIFO_DEPTH_g];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_aligned;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_last;
    logic               w_start_ok;
    logic               w_drop_set;
    logic [CW:0]        w_occ;

    // Column j lags column 0 by j en-cycles, so it is delayed by
    // R_g-1-j en-gated registers to line every lane up with column 0.
    for (genvar j = 0; j < R_g; j++) begin : g_col
        if (j == R_g - 1) begin : g_direct
            assign w_col[j] = sum_i[j*ACC_W +: ACC_W];
        end else begin : g_dly
            localparam int D = R_g - 1 - j;
            logic [ACC_W-1:0] r_dly [D];

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int k = 0; k < D; k++) begin
                        r_dly[k] <= '0;
                    end
                end else if (en_i) begin
                    r_dly[0] <= sum_i[j*ACC_W +: ACC_W];
                    for (int k = 1; k < D; k++) begin
                        r_dly[k] <= r_dly[k-1];
                    end
                end
            end

            assign w_col[j] = r_dly[D-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_vld <= '0;
        end else if (en_i) begin
            r_vld[0] <= valid_i;
            for (int k = 1; k < R_g - 1; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign w_aligned = en_i && r_vld[R_g-2];

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [W_g-1:0] f_quant(
        input logic [ACC_W-1:0] s,
        input logic [4:0]       sh
    );
        logic signed [ACC_W:0] x;
        logic signed [ACC_W:0] rnd;
        x   = $signed({s[ACC_W-1], s});
        rnd = '0;
        if (sh != 5'd0) begin
            rnd = (ACC_W + 1)'(1) << (sh - 5'd1);
        end
        x = (x + rnd) >>> sh;
        if (x > Q_MAX) begin
            x = Q_MAX;
        end else if (x < Q_MIN) begin
            x = Q_MIN;
        end
        return x[W_g-1:0];
    endfunction

    always_comb begin
        w_quant = '0;
        for (int j = 0; j < R_g; j++) begin
            w_quant[j*W_g +: W_g] = f_quant(w_col[j], r_shift);
        end
    end

    // Vectors seen outside a job never enter the quant stage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_q_valid <= 1'b0;
            r_q_data  <= '0;
        end else begin
            r_q_valid <= w_aligned && (r_state == S_RUN);
            if (w_aligned) begin
                r_q_data <= w_quant;
            end
        end
    end

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && m_axis.tready;
    assign w_full  = (r_count == CW'(FIFO_DEPTH_g));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = r_q_valid && (!w_full || w_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < FIFO_DEPTH_g; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_q_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_last     = (r_state == S_RUN) &&
                        (r_out_cnt == r_num_vec - 16'd1);
    assign w_start_ok = start_i && (r_state == S_IDLE);
    assign w_drop_set = (w_aligned && (r_state == S_IDLE)) ||
                        (r_q_valid && !w_push);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_num_vec <= '0;
            r_shift   <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 16'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_num_vec <= num_vec_i;
                        r_shift   <= (shift_i > SH_MAX) ? SH_MAX : shift_i;
                        r_out_cnt <= '0;
                        if (num_vec_i == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_drop_set) begin
                r_drop <= 1'b1;
            end else if (w_start_ok) begin
                r_drop <= 1'b0;
            end
        end
    end

    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_q_valid};
    assign stall_o = (w_occ >= (CW + 1)'(FIFO_DEPTH_g - 1));

    assign m_axis.tvalid = w_valid;
    assign m_axis.tdata  = r_mem[r_rd_ptr];
    assign m_axis.tlast  = w_valid && w_last;

    assign done_o = r_done;
    assign drop_o = r_drop;

endmodule

// File: tb/tb_output_quantizer_slv.sv
// Directed bench for output_quantizer_slv with a queue-based reference model.
// Ports: drives array/job inputs and tready, checks every output each cycle.
module tb_output_quantizer_slv;

    localparam int W   = 8;
    localparam int R   = 8;
    localparam int D   = 4;
    localparam int ACC = 2 * W + $clog2(R);
    localparam int DW  = R * W;
    localparam longint QMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint QMIN = -QMAX - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              valid = 1'b0;
    logic [R*ACC-1:0]  sum = '0;
    logic              start = 1'b0;
    logic [15:0]       num_vec = '0;
    logic [4:0]        shift = '0;
    logic              stall;
    logic              done;
    logic              drop;

    output_quantizer_slv_if #(.DW(DW)) axis ();

    output_quantizer_slv #(
        .W_g(W),
        .R_g(R),
        .FIFO_DEPTH_g(D)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .en_i(en),
        .valid_i(valid),
        .sum_i(sum),
        .start_i(start),
        .num_vec_i(num_vec),
        .shift_i(shift),
        .stall_o(stall),
        .m_axis(axis),
        .done_o(done),
        .drop_o(drop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 0;

    longint vec [16][R];

    logic [DW-1:0] got_d [$];
    bit            got_l [$];
    int            done_cnt = 0;
    bit            stall_seen = 0;

    typedef struct packed {
        logic [31:0]      age;
        logic [R*ACC-1:0] d;
    } part_t;

    part_t         parts [$];
    logic [DW-1:0] m_fifo [$];
    bit            m_run = 0;
    int            m_num = 0;
    int            m_cnt = 0;
    int            m_shift = 0;
    bit            m_qv = 0;
    logic [DW-1:0] m_qd = '0;
    bit            m_done = 0;
    bit            m_drop = 0;

    function automatic logic [W-1:0] mq(longint s, int sh);
        longint r;
        int     e;
        e = (sh > ACC - 1) ? ACC - 1 : sh;
        if (e == 0) r = s;
        else r = (s + (longint'(1) <<< (e - 1))) >>> e;
        if (r > QMAX) r = QMAX;
        if (r < QMIN) r = QMIN;
        return r[W-1:0];
    endfunction

    function automatic logic [DW-1:0] quant_vec(logic [R*ACC-1:0] d, int sh);
        logic [DW-1:0] o;
        longint        s;
        o = '0;
        for (int j = 0; j < R; j++) begin
            s = longint'($signed(d[j*ACC +: ACC]));
            o[j*W +: W] = mq(s, sh);
        end
        return o;
    endfunction

    task automatic model_clear();
        parts.delete();
        m_fifo.delete();
        m_run = 0; m_num = 0; m_cnt = 0; m_shift = 0;
        m_qv = 0; m_qd = '0; m_done = 0; m_drop = 0;
    endtask

    // Reference: partial vectors collect one column per en-cycle,
    // a quant slot feeds a bounded queue, the job counts handshakes.
    initial begin
        bit            pre_run, pop, last_now, complete, done_n, drop_n;
        logic [DW-1:0] cvec, tmp;
        part_t         p;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                pre_run  = m_run;
                pop      = (m_fifo.size() > 0) && axis.tready;
                last_now = pre_run && (m_cnt == m_num - 1);
                done_n   = 0;
                drop_n   = m_drop;
                complete = 0;
                cvec     = '0;
                if (start && !pre_run) drop_n = 0;
                if (en) begin
                    if (valid) parts.push_back('{age: 32'd0, d: '0});
                    foreach (parts[i]) begin
                        p = parts[i];
                        p.d[p.age*ACC +: ACC] = sum[p.age*ACC +: ACC];
                        p.age = p.age + 1;
                        parts[i] = p;
                    end
                    if (parts.size() > 0 && parts[0].age == R) begin
                        p = parts.pop_front();
                        cvec = quant_vec(p.d, m_shift);
                        complete = 1;
                    end
                end
                if (pop) begin
                    tmp = m_fifo.pop_front();
                    m_cnt++;
                    if (last_now) begin
                        m_run  = 0;
                        done_n = 1;
                    end
                end
                if (m_qv) begin
                    if (m_fifo.size() < D) m_fifo.push_back(m_qd);
                    else drop_n = 1;
                end
                m_qv = 0;
                if (complete) begin
                    if (!pre_run) drop_n = 1;
                    else begin
                        m_qv = 1;
                        m_qd = cvec;
                    end
                end
                if (start && !pre_run) begin
                    m_num   = int'(num_vec);
                    m_shift = int'(shift);
                    m_cnt   = 0;
                    if (num_vec == 16'd0) done_n = 1;
                    else m_run = 1;
                end
                m_done = done_n;
                m_drop = drop_n;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        bit            ev, el, es;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                ev = m_fifo.size() > 0;
                ed = ev ? m_fifo[0] : '0;
                el = ev && m_run && (m_cnt == m_num - 1);
                es = (m_fifo.size() + int'(m_qv)) >= D - 1;
                n_tests++;
                if (axis.tvalid !== ev || axis.tlast !== el ||
                    stall !== es || done !== m_done ||
                    drop !== m_drop || (ev && axis.tdata !== ed)) begin
                    n_fail++;
                    $display("FAIL cycle_cmp t=%0t got v%b l%b s%b dn%b dr%b d=%h want v%b l%b s%b dn%b dr%b d=%h",
                             $time, axis.tvalid, axis.tlast, stall, done,
                             drop, axis.tdata, ev, el, es, m_done, m_drop, ed);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && axis.tvalid && axis.tready) begin
                got_d.push_back(axis.tdata);
                got_l.push_back(axis.tlast);
            end
            if (done) done_cnt++;
            if (stall) stall_seen = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic start_job(int n, int sh);
        @(posedge clk); #1;
        start   = 1'b1;
        num_vec = 16'(n);
        shift   = 5'(sh);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Skewed feed: in slot k column j carries vector k-j.
    task automatic feed(int n, bit honour);
        int k   = 0;
        int cyc = 0;
        while (k < n + R - 1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (honour && stall) begin
                en    = 1'b0;
                valid = 1'b0;
            end else begin
                en    = 1'b1;
                valid = (k < n);
                for (int j = 0; j < R; j++) begin
                    if (k - j >= 0 && k - j < n)
                        sum[j*ACC +: ACC] = ACC'(vec[k-j][j]);
                    else
                        sum[j*ACC +: ACC] = '0;
                end
                k++;
            end
        end
        check("feed_complete", 64'(k), 64'(n + R - 1));
        @(posedge clk); #1;
        en    = 1'b0;
        valid = 1'b0;
        sum   = '0;
    endtask

    task automatic wait_done(string name, int budget);
        int c0 = done_cnt;
        int c  = 0;
        while (done_cnt == c0 && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        repeat (3) @(negedge clk);
        #1;
        check(name, 64'(done_cnt - c0), 64'd1);
    endtask

    task automatic clear_got();
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        logic [DW-1:0] e;
        int            c;
        int            dc;

        axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 cmp_on = 1;
        @(negedge clk); #1 rst_n = 1'b1;
        check("rst_tvalid", 64'(axis.tvalid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);

        // Identity requantization.
        clear_got();
        axis.tready = 1'b1;
        for (int j = 0; j < R; j++) vec[0][j] = j + 1;
        start_job(1, 0);
        feed(1, 0);
        wait_done("id_done", 60);
        check("id_beats", 64'(got_d.size()), 64'd1);
        check("id_data", got_d[0], 64'h0807060504030201);
        check("id_last", 64'(got_l[0]), 64'd1);

        // Rounding and saturation at shift 4.
        clear_got();
        vec[0][0] = 24;    vec[0][1] = 23;  vec[0][2] = -24;
        vec[0][3] = 5000;  vec[0][4] = -5000;
        vec[0][5] = 0;     vec[0][6] = 0;   vec[0][7] = 0;
        start_job(1, 4);
        feed(1, 0);
        wait_done("rnd_done", 60);
        check("rnd_data", got_d[0], 64'h000000807FFF0102);

        // Backpressure with stall honoured.
        clear_got();
        axis.tready = 1'b0;
        stall_seen  = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < R; j++) vec[i][j] = 16 * (i + 1) + j;
        start_job(5, 0);
        fork
            feed(5, 1);
            begin
                repeat (40) @(posedge clk);
                #1 axis.tready = 1'b1;
            end
        join
        wait_done("bp_done", 200);
        check("bp_stall_seen", 64'(stall_seen), 64'd1);
        check("bp_no_drop", 64'(drop), 64'd0);
        check("bp_beats", 64'(got_d.size()), 64'd5);
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            e = '0;
            for (int j = 0; j < R; j++) e[j*W +: W] = 8'(16 * (i + 1) + j);
            check("bp_data", got_d[i], e);
            check("bp_last", 64'(got_l[i]), 64'(i == 4));
        end

        // Overflow: stall ignored, 6 vectors into a 4-deep FIFO.
        clear_got();
        axis.tready = 1'b0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < R; j++) vec[i][j] = i + 1;
        start_job(4, 0);
        feed(6, 0);
        repeat (3) @(negedge clk);
        #1 check("ovf_drop", 64'(drop), 64'd1);
        @(posedge clk); #1 axis.tready = 1'b1;
        wait_done("ovf_done", 100);
        check("ovf_beats", 64'(got_d.size()), 64'd4);
        check("ovf_last", 64'(got_l[3]), 64'd1);

        // Zero-length job clears the sticky drop and emits nothing.
        clear_got();
        start_job(0, 0);
        wait_done("nv0_done", 20);
        check("nv0_drop_clr", 64'(drop), 64'd0);
        check("nv0_beats", 64'(got_d.size()), 64'd0);

        // Vector arriving while idle.
        clear_got();
        for (int j = 0; j < R; j++) vec[0][j] = 3;
        feed(1, 0);
        repeat (2) @(negedge clk);
        #1 check("idle_drop", 64'(drop), 64'd1);
        check("idle_beats", 64'(got_d.size()), 64'd0);
        start_job(0, 0);
        wait_done("idle_clr_done", 20);
        check("idle_drop_clr", 64'(drop), 64'd0);

        // Reset after 2 of 4 beats.
        clear_got();
        axis.tready = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < R; j++) vec[i][j] = 10 * (i + 1);
        start_job(4, 0);
        feed(4, 0);
        repeat (3) @(posedge clk);
        #1 axis.tready = 1'b1;
        c = 0;
        while (got_d.size() < 2 && c < 100) begin
            @(negedge clk); #1;
            c++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 check("rstm_tvalid", 64'(axis.tvalid), 64'd0);
        check("rstm_beats", 64'(got_d.size()), 64'd2);
        axis.tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        dc = done_cnt;
        repeat (10) @(negedge clk);
        #1;
        check("rstm_no_done", 64'(done_cnt - dc), 64'd0);
        check("rstm_no_drop", 64'(drop), 64'd0);
        check("rstm_idle", 64'(axis.tvalid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_quantizer_slv.md
# output_quantizer_slv

Downstream stage of the systolic array in the accelerator. Consumes the column-skewed partial sums (`sum_out`) and re-aligns them into whole output vectors. Each lane is requantized (arithmetic shift, round-half-up, saturate) to `W_g` bits. Results are buffered and streamed out as packed `R_g*W_g`-bit beats on an AXI-Stream master toward the write-back DMA, with a stall signal that gates the array's enable.

## Interface
- `W_g`, 8, output lane width in bits; also the operand width of the array
- `R_g`, 8, number of array columns / output lanes
- `FIFO_DEPTH_g`, 4, output FIFO entries; must be ≥ 4 and a power of 2
- Derived: `ACC_W = 2*W_g + $clog2(R_g)`, 19 by default

Ports:
- `clk_i`  in  1  single clock, rising edge
- `rst_n_i`  in  1  reset, asynchronous and active-low
- `en_i`  in  1  array advanced this cycle; same signal as the systolic `en`
- `valid_i`  in  1  qualified by `en_i`; column 0 of `sum_i` holds a real result
- `sum_i`  in  `R_g*ACC_W`  signed column sums; column j is `[j*ACC_W +: ACC_W]`
- `start_i`  in  1  single-cycle job start; honoured only in IDLE
- `num_vec_i`  in  16  number of output vectors in the job; latched on start
- `shift_i`  in  5  requant right-shift; latched on start
- `stall_o`  out  1  upstream must hold `en_i` low while this is high
- `m_axis_tvalid_o`  out  1  output beat valid
- `m_axis_tready_i`  in  1  output beat accepted
- `m_axis_tdata_o`  out  `R_g*W_g`  lane j is `[j*W_g +: W_g]`
- `m_axis_tlast_o`  out  1  last beat of the job
- `done_o`  out  1  one-cycle pulse after the last beat handshake
- `drop_o`  out  1  sticky error flag: a vector was discarded; cleared by `start_i`

## Operation
- **State machine.** States are IDLE and RUN.
  - IDLE to RUN on `start_i`. This latches `num_vec_i` and `shift_i` and clears the vector counter and `drop_o`.
  - `start_i` with `num_vec_i == 0`: stay in IDLE and pulse `done_o` on the next cycle.
  - `start_i` while in RUN is ignored.
  - RUN to IDLE on the output handshake where the counter equals `num_vec-1`. `done_o` is high the following cycle.
- **Deskew.** Column j passes through `R_g-1-j` registers that advance only when `en_i` is high. Column `R_g-1` is taken directly from `sum_i`.
  - `valid_i` passes through an `R_g-1` stage shift register that also advances only on `en_i`.
  - An aligned vector exists in a cycle where `en_i` is high and the last valid tap is 1.
  - Column j of a given vector therefore arrives j en-cycles after column 0.
- **Requantization**, per lane, signed:
  - `r = (s + (shift ? 1<<(shift-1) : 0)) >>> shift`, computed in `ACC_W+1` bits so the rounding add cannot overflow.
  - `shift` values greater than `ACC_W-1` are treated as `ACC_W-1`.
  - Saturate to [`-2^(W_g-1)`, `2^(W_g-1)-1`].
- **Datapath.** The aligned vector is requantized into a single register stage (`q_valid`), then written into the FIFO.
- **Stall.** `stall_o = (fifo_count + q_valid) >= FIFO_DEPTH_g-1`, combinational.
  - If upstream honours `stall_o`, the FIFO never overflows.
  - If an aligned vector arrives with the FIFO full, or while in IDLE, it is discarded and `drop_o` is set.
- **Tlast.** `m_axis_tlast_o` is high when the FIFO head is the job's vector index `num_vec-1`. Vector index is tracked by the counter at the output side.
- **Drain.** Upstream must keep issuing `en_i` for `R_g-1` cycles after the last `valid_i` to flush the skew; this block does not self-flush.

## Timing
- **Reset.** All outputs low; `stall_o` low; FIFO empty; deskew and valid registers zero; state IDLE. Asserting `rst_n_i` mid-job aborts immediately with no `done_o`.
- **Latency.** An aligned vector in cycle T is in the quant stage in T+1. With an empty FIFO, `m_axis_tvalid_o` is high in T+2.
- **AXI-Stream rules.** While `m_axis_tvalid_o` is high and `m_axis_tready_i` is low, `m_axis_tdata_o` and `m_axis_tlast_o` hold stable. Valid never depends on ready.
- **Simultaneous FIFO push and pop** in the same cycle is allowed when full; count is unchanged and nothing is dropped.
- **Throughput.** One beat per cycle when `en_i` is high continuously and `m_axis_tready_i` is high continuously.
- **End of job.** `done_o` fires exactly once, in the cycle after the tlast handshake. A new `start_i` is accepted in that same `done_o` cycle.

## Test plan
- **Identity requant.** R_g=8, `shift=0`, column sums j+1 fed with correct skew, `num_vec=1`: beat tdata = 0x0807060504030201, tlast=1, `done_o` one cycle after the handshake.
- **Rounding and saturation.** `shift=4`, lane sums 24, 23, -24, 5000, -5000: lane values 2, 1, -1, 127, -128.
- **Backpressure.** `FIFO_DEPTH_g=4`, tready held low while 5 vectors are pushed with `stall_o` honoured:
  - `stall_o` high once occupancy reaches 3;
  - no drop;
  - releasing tready yields 5 beats in order, with tlast on the 5th.
- **Overflow.** Ignore `stall_o` and push 6 vectors with tready low: `drop_o`=1, exactly 4 beats emerge, and `drop_o` clears on the next start.
- **Edge starts.** `num_vec=0`: `done_o` pulses with no beats. Vectors arriving while IDLE are dropped and `drop_o` is set.
- **Reset mid-job.** After 2 of 4 beats, assert `rst_n_i`: tvalid goes low immediately, and there is no `done_o` or `drop_o` after release.
